// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR/trap unit: access types, CSR map, cause codes.
// Pure declarations; no timing or flow-control behaviour.
package csr_pkg;

    typedef enum logic [1:0] {
        READ_ONLY = 2'd0,
        WRITE     = 2'd1,
        SET       = 2'd2,
        CLEAR     = 2'd3
    } access_t;

    typedef enum logic [11:0] {
        CSR_MSTATUS       = 12'h300,
        CSR_MISA          = 12'h301,
        CSR_MIE           = 12'h304,
        CSR_MTVEC         = 12'h305,
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MSCRATCH      = 12'h340,
        CSR_MEPC          = 12'h341,
        CSR_MCAUSE        = 12'h342,
        CSR_MTVAL         = 12'h343,
        CSR_MIP           = 12'h344,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_MVENDORID     = 12'hF11,
        CSR_MARCHID       = 12'hF12,
        CSR_MIMPID        = 12'hF13,
        CSR_MHARTID       = 12'hF14
    } csr_addr_t;

    localparam int CAUSE_MSI    = 3;
    localparam int CAUSE_MTI    = 7;
    localparam int CAUSE_MEI    = 11;
    localparam int CAUSE_LOCAL0 = 16;

    localparam int MIP_MSI_BIT    = CAUSE_MSI;
    localparam int MIP_MTI_BIT    = CAUSE_MTI;
    localparam int MIP_MEI_BIT    = CAUSE_MEI;
    localparam int MIP_LOCAL0_BIT = CAUSE_LOCAL0;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // Writable/visible bits of mip/mie for a given number of platform lines.
    function automatic logic [31:0] irq_mask(input int n);
        logic [31:0] m;
        m = '0;
        m[MIP_MSI_BIT] = 1'b1;
        m[MIP_MTI_BIT] = 1'b1;
        m[MIP_MEI_BIT] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < n) m[MIP_LOCAL0_BIT + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// 64-bit event counter with inhibit and independent low/high half writes.
// Latency: one cycle; a half write wins over the increment in that cycle.
module csr_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_inc,
    input  logic        i_inhibit,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wr_dat,
    output logic [63:0] o_cnt
);

    logic [63:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_wr_lo) begin
            r_cnt[31:0] <= i_wr_dat;
        end else if (i_wr_hi) begin
            r_cnt[63:32] <= i_wr_dat;
        end else if (i_inc && !i_inhibit) begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap unit: CSR access, trap entry/return, interrupt request, counters.
// Latency: reads/trap_pc/interrupted combinational, state updates on next clk; no backpressure.
module csr_file
    import csr_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] RESET_TVEC    = 32'h0,
    parameter logic [31:0] HART_ID       = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [11:0]              csr_id,
    input  logic [1:0]               access_type,
    input  logic [31:0]              in,
    output logic [31:0]              out,
    output logic                     illegal_access,
    input  logic                     external_interrupt,
    input  logic                     timer_interrupt,
    input  logic                     software_interrupt,
    input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
    input  logic                     exception,
    input  logic [30:0]              exception_cause,
    input  logic [31:0]              trap_value,
    input  logic                     handle_trap,
    input  logic                     exit_trap,
    input  logic                     instret,
    input  logic [31:0]              current_pc,
    output logic [31:0]              trap_pc,
    output logic [31:0]              ret_pc,
    output logic                     interrupted
);

    localparam logic [31:0] IRQ_MASK = irq_mask(NUM_LOCAL_IRQ);

    logic        r_mst_mie, r_mpie, r_cy, r_ir;
    logic [31:0] r_mie, r_mtvec, r_mscratch, r_mcause, r_mtval;
    logic [29:0] r_mepc;

    logic [31:0] w_mip, w_pend, w_next, w_mstatus, w_base;
    logic [63:0] w_mcycle, w_minstret;
    logic [4:0]  w_irq_cause;
    logic [1:0]  w_tvec_mode;
    logic        w_impl, w_we, w_we_reg;
    logic        w_unused_ok;

    assign w_unused_ok = &{1'b0, current_pc[1:0]};

    always_comb begin
        w_mip = '0;
        w_mip[MIP_MSI_BIT] = software_interrupt;
        w_mip[MIP_MTI_BIT] = timer_interrupt;
        w_mip[MIP_MEI_BIT] = external_interrupt;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            w_mip[MIP_LOCAL0_BIT + i] = local_irq[i];
        end
    end

    assign w_pend      = w_mip & r_mie;
    assign interrupted = r_mst_mie & (|w_pend);

    // Later assignments win: lowest local line first among locals, then MTI, MSI, MEI on top.
    always_comb begin
        w_irq_cause = 5'd0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (w_pend[CAUSE_LOCAL0 + i]) w_irq_cause = 5'(CAUSE_LOCAL0 + i);
        end
        if (w_pend[CAUSE_MTI]) w_irq_cause = 5'(CAUSE_MTI);
        if (w_pend[CAUSE_MSI]) w_irq_cause = 5'(CAUSE_MSI);
        if (w_pend[CAUSE_MEI]) w_irq_cause = 5'(CAUSE_MEI);
    end

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mst_mie, 3'd0};

    always_comb begin
        out    = '0;
        w_impl = 1'b1;
        case (csr_id)
            CSR_MSTATUS:       out = w_mstatus;
            CSR_MISA:          out = MISA_VALUE;
            CSR_MIE:           out = r_mie;
            CSR_MIP:           out = w_mip;
            CSR_MTVEC:         out = r_mtvec;
            CSR_MCOUNTINHIBIT: out = {29'd0, r_ir, 1'b0, r_cy};
            CSR_MSCRATCH:      out = r_mscratch;
            CSR_MEPC:          out = {r_mepc, 2'b00};
            CSR_MCAUSE:        out = r_mcause;
            CSR_MTVAL:         out = r_mtval;
            CSR_MCYCLE:        out = w_mcycle[31:0];
            CSR_MCYCLEH:       out = w_mcycle[63:32];
            CSR_MINSTRET:      out = w_minstret[31:0];
            CSR_MINSTRETH:     out = w_minstret[63:32];
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:        out = '0;
            CSR_MHARTID:       out = HART_ID;
            default:           w_impl = 1'b0;
        endcase
    end

    assign illegal_access = !w_impl ||
        ((access_type != READ_ONLY) && ((csr_id[11:10] == 2'b11) || (csr_id == CSR_MIP)));

    always_comb begin
        case (access_type)
            WRITE:   w_next = in;
            SET:     w_next = out | in;
            CLEAR:   w_next = out & ~in;
            default: w_next = out;
        endcase
    end

    assign w_we        = (access_type != READ_ONLY) && !illegal_access;
    assign w_we_reg    = w_we && !handle_trap && !exit_trap;
    assign w_tvec_mode = (VECTORED_EN && (w_next[1:0] == 2'b01)) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mst_mie  <= 1'b0;
            r_mpie     <= 1'b0;
            r_mie      <= '0;
            r_mtvec    <= RESET_TVEC;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_cy       <= 1'b0;
            r_ir       <= 1'b0;
        end else if (handle_trap) begin
            r_mepc    <= current_pc[31:2];
            r_mpie    <= r_mst_mie;
            r_mst_mie <= 1'b0;
            r_mtval   <= trap_value;
            r_mcause  <= exception ? {1'b0, exception_cause} : {1'b1, 26'd0, w_irq_cause};
        end else if (exit_trap) begin
            r_mst_mie <= r_mpie;
            r_mpie    <= 1'b1;
        end else if (w_we_reg) begin
            case (csr_id)
                CSR_MSTATUS: begin
                    r_mst_mie <= w_next[3];
                    r_mpie    <= w_next[7];
                end
                CSR_MIE:      r_mie      <= w_next & IRQ_MASK;
                CSR_MTVEC:    r_mtvec    <= {w_next[31:2], w_tvec_mode};
                CSR_MCOUNTINHIBIT: begin
                    r_cy <= w_next[0];
                    r_ir <= w_next[2];
                end
                CSR_MSCRATCH: r_mscratch <= w_next;
                CSR_MEPC:     r_mepc     <= w_next[31:2];
                CSR_MCAUSE:   r_mcause   <= w_next;
                CSR_MTVAL:    r_mtval    <= w_next;
                default: ;
            endcase
        end
    end

    csr_counter u_mcycle (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_inc     (1'b1),
        .i_inhibit (r_cy),
        .i_wr_lo   (w_we && (csr_id == CSR_MCYCLE)),
        .i_wr_hi   (w_we && (csr_id == CSR_MCYCLEH)),
        .i_wr_dat  (w_next),
        .o_cnt     (w_mcycle)
    );

    csr_counter u_minstret (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_inc     (instret),
        .i_inhibit (r_ir),
        .i_wr_lo   (w_we && (csr_id == CSR_MINSTRET)),
        .i_wr_hi   (w_we && (csr_id == CSR_MINSTRETH)),
        .i_wr_dat  (w_next),
        .o_cnt     (w_minstret)
    );

    // Vector offset comes from the registered mcause, so it is valid the cycle after the trap.
    assign w_base  = {r_mtvec[31:2], 2'b00};
    assign trap_pc = ((r_mtvec[1:0] == 2'b01) && r_mcause[31]) ? (w_base + {r_mcause[29:0], 2'b00})
                                                                 : w_base;
    assign ret_pc  = {r_mepc, 2'b00};

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset, CSR access rules, trap entry/return, priority, counters.
module tb_csr_file;
    import csr_pkg::*;

    localparam logic [31:0] TVEC0 = 32'h0000_1000;
    localparam logic [31:0] HID   = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] csr_id;
    logic [1:0]  access_type;
    logic [31:0] in;
    logic [31:0] out;
    logic        illegal_access;
    logic        external_interrupt, timer_interrupt, software_interrupt;
    logic [3:0]  local_irq;
    logic        exception;
    logic [30:0] exception_cause;
    logic [31:0] trap_value;
    logic        handle_trap, exit_trap, instret;
    logic [31:0] current_pc, trap_pc, ret_pc;
    logic        interrupted;

    int checks = 0;
    int errors = 0;

    csr_file #(
        .NUM_LOCAL_IRQ (4),
        .VECTORED_EN   (1'b1),
        .RESET_TVEC    (TVEC0),
        .HART_ID       (HID)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .csr_id             (csr_id),
        .access_type        (access_type),
        .in                 (in),
        .out                (out),
        .illegal_access     (illegal_access),
        .external_interrupt (external_interrupt),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt),
        .local_irq          (local_irq),
        .exception          (exception),
        .exception_cause    (exception_cause),
        .trap_value         (trap_value),
        .handle_trap        (handle_trap),
        .exit_trap          (exit_trap),
        .instret            (instret),
        .current_pc         (current_pc),
        .trap_pc            (trap_pc),
        .ret_pc             (ret_pc),
        .interrupted        (interrupted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] id, input logic [1:0] t, input logic [31:0] v);
        csr_id = id; access_type = t; in = v;
        tick();
        access_type = READ_ONLY; in = '0;
    endtask

    task automatic rd(input string tag, input logic [11:0] id, input logic [31:0] exp);
        csr_id = id; access_type = READ_ONLY;
        #1;
        check(tag, out, exp);
    endtask

    task automatic trap(input logic exc, input logic [30:0] cause, input logic [31:0] pc,
                        input logic [31:0] tval, input logic with_exit);
        handle_trap = 1'b1; exit_trap = with_exit; exception = exc;
        exception_cause = cause; current_pc = pc; trap_value = tval;
        tick();
        handle_trap = 1'b0; exit_trap = 1'b0; exception = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        csr_id = '0; access_type = READ_ONLY; in = '0;
        external_interrupt = 0; timer_interrupt = 0; software_interrupt = 0; local_irq = '0;
        exception = 0; exception_cause = '0; trap_value = '0;
        handle_trap = 0; exit_trap = 0; instret = 0; current_pc = '0;
        tick();
        check("rst_interrupted", interrupted, 0);
        check("rst_ret_pc", ret_pc, 0);
        check("rst_trap_pc", trap_pc, TVEC0);
        rd("rst_mtvec", CSR_MTVEC, TVEC0);
        rd("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        rd("misa", CSR_MISA, 32'h4000_0100);
        tick();
        reset_n = 1'b1;
        tick();

        // mtvec legalisation and vectored external-interrupt trap
        csr_wr(CSR_MTVEC, WRITE, 32'h8000_0102);
        rd("mtvec_bad_mode", CSR_MTVEC, 32'h8000_0100);
        csr_wr(CSR_MTVEC, WRITE, 32'h8000_0101);
        rd("mtvec_vec", CSR_MTVEC, 32'h8000_0101);
        csr_wr(CSR_MIE, SET, 32'h0000_0800);
        csr_wr(CSR_MSTATUS, SET, 32'h0000_0008);
        rd("mstatus_mie", CSR_MSTATUS, 32'h0000_1808);
        external_interrupt = 1'b1;
        #1;
        check("irq_req", interrupted, 1);
        trap(1'b0, '0, 32'h0000_1237, 32'h0000_DEAD, 1'b0);
        rd("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
        check("mei_trap_pc", trap_pc, 32'h8000_012C);
        rd("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
        rd("trap_mepc", CSR_MEPC, 32'h0000_1234);
        rd("trap_mtval", CSR_MTVAL, 32'h0000_DEAD);
        check("irq_masked", interrupted, 0);

        // interrupt priority
        csr_wr(CSR_MIE, WRITE, 32'hFFFF_FFFF);
        rd("mie_mask", CSR_MIE, 32'h000F_0888);
        timer_interrupt = 1'b1; local_irq = 4'b0001;
        rd("mip_view", CSR_MIP, 32'h0001_0880);
        csr_wr(CSR_MSTATUS, SET, 32'h8);
        trap(1'b0, '0, 32'h100, '0, 1'b0);
        rd("prio_mei", CSR_MCAUSE, 32'h8000_000B);
        external_interrupt = 1'b0;
        csr_wr(CSR_MSTATUS, SET, 32'h8);
        trap(1'b0, '0, 32'h100, '0, 1'b0);
        rd("prio_mti", CSR_MCAUSE, 32'h8000_0007);
        check("mti_trap_pc", trap_pc, 32'h8000_011C);
        timer_interrupt = 1'b0;
        csr_wr(CSR_MSTATUS, SET, 32'h8);
        trap(1'b0, '0, 32'h100, '0, 1'b0);
        rd("prio_local0", CSR_MCAUSE, 32'h8000_0010);
        check("local0_trap_pc", trap_pc, 32'h8000_0140);
        csr_id = CSR_MIP; access_type = WRITE; in = 32'hFFFF_FFFF;
        #1;
        check("mip_wr_illegal", illegal_access, 1);
        tick();
        access_type = READ_ONLY; in = '0;
        rd("mip_unchanged", CSR_MIP, 32'h0001_0000);
        local_irq = '0;

        // synchronous exception uses the base address
        trap(1'b1, 31'd2, 32'h300, 32'h55, 1'b0);
        rd("exc_mcause", CSR_MCAUSE, 32'h0000_0002);
        check("exc_trap_pc", trap_pc, 32'h8000_0100);

        // trap and mret together, then mret alone
        csr_wr(CSR_MSTATUS, WRITE, 32'h8);
        rd("mstatus_wr", CSR_MSTATUS, 32'h0000_1808);
        trap(1'b1, 31'd5, 32'h0000_2003, '0, 1'b1);
        rd("both_mstatus", CSR_MSTATUS, 32'h0000_1880);
        rd("both_mcause", CSR_MCAUSE, 32'h0000_0005);
        check("both_ret_pc", ret_pc, 32'h0000_2000);
        exit_trap = 1'b1;
        tick();
        exit_trap = 1'b0;
        rd("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
        check("mret_ret_pc", ret_pc, 32'h0000_2000);

        // illegal accesses and SET/CLEAR
        csr_id = CSR_MHARTID; access_type = WRITE; in = '0;
        #1;
        check("hartid_wr_illegal", illegal_access, 1);
        tick();
        access_type = READ_ONLY;
        rd("hartid_value", CSR_MHARTID, HID);
        check("hartid_rd_legal", illegal_access, 0);
        rd("unimpl_out", 12'h7C0, 32'h0);
        check("unimpl_illegal", illegal_access, 1);
        csr_wr(CSR_MSCRATCH, WRITE, 32'hA5A5_A5A5);
        csr_wr(CSR_MSCRATCH, CLEAR, 32'h0000_FFFF);
        rd("mscratch_clear", CSR_MSCRATCH, 32'hA5A5_0000);
        csr_wr(CSR_MSCRATCH, SET, 32'h0000_0F0F);
        rd("mscratch_set", CSR_MSCRATCH, 32'hA5A5_0F0F);

        // mcycle carry into the high half, then freeze
        csr_wr(CSR_MCYCLE, WRITE, 32'hFFFF_FFFF);
        csr_wr(CSR_MCYCLEH, WRITE, 32'h0);
        rd("mcycle_pre", CSR_MCYCLE, 32'hFFFF_FFFF);
        rd("mcycleh_pre", CSR_MCYCLEH, 32'h0);
        tick();
        rd("mcycle_wrap", CSR_MCYCLE, 32'h0);
        rd("mcycleh_carry", CSR_MCYCLEH, 32'h1);
        csr_wr(CSR_MCOUNTINHIBIT, WRITE, 32'h1);
        tick(); tick(); tick();
        rd("mcycle_frozen", CSR_MCYCLE, 32'h1);
        rd("mcycleh_frozen", CSR_MCYCLEH, 32'h1);
        rd("inhibit_cy", CSR_MCOUNTINHIBIT, 32'h1);
        instret = 1'b1;
        tick(); tick(); tick();
        instret = 1'b0;
        rd("minstret_count", CSR_MINSTRET, 32'h3);
        csr_wr(CSR_MCOUNTINHIBIT, SET, 32'h4);
        instret = 1'b1;
        tick(); tick();
        instret = 1'b0;
        rd("minstret_frozen", CSR_MINSTRET, 32'h3);
        rd("inhibit_both", CSR_MCOUNTINHIBIT, 32'h5);

        // asynchronous reset mid-run
        csr_wr(CSR_MIE, WRITE, 32'h0001_0000);
        local_irq = 4'b0001;
        csr_wr(CSR_MSTATUS, SET, 32'h8);
        check("pre_rst_irq", interrupted, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_interrupted", interrupted, 0);
        check("arst_trap_pc", trap_pc, TVEC0);
        check("arst_ret_pc", ret_pc, 0);
        rd("arst_mcycleh", CSR_MCYCLEH, 32'h0);
        rd("arst_mcycle", CSR_MCYCLE, 32'h0);
        rd("arst_minstret", CSR_MINSTRET, 32'h0);
        rd("arst_mtvec", CSR_MTVEC, TVEC0);
        rd("arst_mie", CSR_MIE, 32'h0);
        tick();
        reset_n = 1'b1;
        local_irq = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode CSR and trap unit, successor to the single-hart CSR block. Adds configurable platform interrupt lines with an `mip` view, vectored `mtvec` mode, 64-bit `mcycle`/`minstret` counters with `mcountinhibit`, and illegal-access detection. It sits beside the execute stage: decode supplies CSR accesses, the core supplies trap/return strobes, and the block returns the read data, trap/return PCs and the interrupt request.

## Interface
Parameters:
- `NUM_LOCAL_IRQ`, 4: platform interrupt lines (1..16), mapped to cause/bit 16+i.
- `VECTORED_EN`, 1: 1 allows `mtvec.MODE`=1; 0 forces MODE to 0.
- `RESET_TVEC`, 32'h0: reset value of `mtvec` (bits [1:0] must be 0).
- `HART_ID`, 0: value returned by `mhartid`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `csr_id` in 12: CSR address.
- `access_type` in 2: `csr_pkg` access type (READ_ONLY/WRITE/SET/CLEAR).
- `in` in 32: write operand.
- `out` out 32: current CSR value (combinational).
- `illegal_access` out 1: unimplemented CSR, or a write to a read-only CSR (combinational).
- `external_interrupt`, `timer_interrupt`, `software_interrupt` in 1: level-sensitive MEIP/MTIP/MSIP.
- `local_irq` in NUM_LOCAL_IRQ: level-sensitive platform interrupts.
- `exception` in 1; `exception_cause` in 31; `trap_value` in 32.
- `handle_trap` in 1: trap taken this cycle. `exit_trap` in 1: `mret` retiring.
- `instret` in 1: one instruction retired this cycle.
- `current_pc` in 32; `trap_pc` out 32; `ret_pc` out 32.
- `interrupted` out 1: an enabled interrupt is pending and `mstatus.MIE`=1.

## Operation
- CSRs: `mstatus` (MIE bit 3, MPIE bit 7, MPP [12:11] reads 2'b11), `misa` (32'h40000100), `mie`, `mip` (read-only), `mtvec`, `mscratch`, `mepc`, `mcause`, `mtval`, `mcycle`/`mcycleh`, `minstret`/`minstreth`, `mcountinhibit` (bit 0 CY, bit 2 IR), `mvendorid`/`marchid`/`mimpid`=0, `mhartid`=HART_ID.
- `mip`/`mie` layout: bit 3 MSI, bit 7 MTI, bit 11 MEI, bit 16+i local i; unimplemented bits read 0 and ignore writes.
- `next` = `in` (WRITE), `out|in` (SET), `out&~in` (CLEAR). No write for READ_ONLY or when `illegal_access`=1.
- `illegal_access`=1 if `csr_id` is unimplemented (`out`=0), or if `access_type`≠READ_ONLY and `csr_id`[11:10]=2'b11 or `csr_id`=`mip`.
- Interrupt priority, highest first: MEI(11), MSI(3), MTI(7), then local 0 (16) up to local N-1.
- `handle_trap`: `mepc`←`current_pc`[31:2]; MPIE←MIE; MIE←0; `mtval`←`trap_value`; `mcause`←{0,`exception_cause`} if `exception`, else {1, highest-priority pending enabled cause}.
- `exit_trap`: MIE←MPIE; MPIE←1.
- Priority: `handle_trap` > `exit_trap` > CSR write. Counters are independent of this chain.
- `trap_pc`: base=`mtvec`[31:2]<<2. Use base+4×cause when MODE=1 and `mcause`[31]=1; otherwise base. `mtvec` writes with MODE∉{0,1}, or MODE=1 with `VECTORED_EN`=0, store MODE 0.
- `ret_pc`={`mepc`[31:2],2'b0}.
- `mcycle` increments by 1 every cycle unless CY=1. `minstret` increments on `instret` unless IR=1. Both wrap modulo 2^64.
- A CSR write to a counter half replaces that half. The other half keeps its pre-increment value, and the increment is suppressed that cycle.

## Timing
- Reads, `illegal_access`, `interrupted`, `trap_pc`, `ret_pc`: combinational, zero latency.
- All state updates land on the next rising `clk` after the strobe/access.
- `trap_pc` for a vectored trap is valid the cycle after `handle_trap`, because it uses the updated `mcause`.
- `reset_n` low, at any time: immediately clear MIE, MPIE, `mie`, `mepc`, `mcause`, `mtval`, `mscratch`, counters and `mcountinhibit`, and set `mtvec`=RESET_TVEC. Outputs then read `interrupted`=0, `ret_pc`=0, `trap_pc`=RESET_TVEC.
- Interrupt inputs are not latched. `mip` follows the inputs combinationally.

## Structure
- `csr_pkg`: access-type enum, CSR address enum (including counters, `mip`, `mcountinhibit`), interrupt cause constants (3/7/11/16), `mip`/`mie` bit positions.
- Sub-module `csr_counter`: 64-bit counter with `inc`, `inhibit`, low/high write-enables and data. It is instantiated twice.

## Test plan
- Reset mid-run: counters nonzero, `reset_n`=0 → `mcycle`=0, `mtvec`=RESET_TVEC, `interrupted`=0 immediately.
- Write `mtvec`=32'h8000_0101, set `mie` bit 11 and MIE, raise `external_interrupt`, pulse `handle_trap` → `mcause`=32'h8000_000B, `trap_pc`=32'h8000_012C, MIE=0, MPIE=1.
- Assert MEI+MTI+local 0 all enabled → cause 11. Drop MEI → cause 7. Drop MTI → cause 16.
- Set `mcycle`=32'hFFFF_FFFF with `mcycleh`=0 → next cycles show `mcycleh`=1, `mcycle`=0. Set CY → the count freezes.
- Write `mhartid`, then write `mip` → `illegal_access`=1 and values unchanged. Read 12'h7C0 → `out`=0 and `illegal_access`=1.
- `handle_trap` and `exit_trap` in the same cycle → trap semantics only. `mret` afterwards → MIE restored, MPIE=1, `ret_pc`=saved `current_pc` with bits [1:0] cleared.
